// File: rtl/overcurrent_guard_pkg.sv
// Shared types and parameter defaults for the dual-channel overcurrent guard.
package overcurrent_guard_pkg;

    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        TRIP     = 2'd1,
        COOLDOWN = 2'd2,
        LOCKOUT  = 2'd3
    } ch_state_e;

    localparam int unsigned FILTER_CYCLES_DEF   = 4;
    localparam int unsigned COOLDOWN_CYCLES_DEF = 16;
    localparam int unsigned MAX_RETRIES_DEF     = 3;
    localparam int unsigned CLEAR_CYCLES_DEF    = 64;

    // Retry counter width; MAX_RETRIES must fit in it.
    localparam int unsigned RETRY_W = 2;
    // Direction bits owned by each channel.
    localparam int unsigned CH_DIR_W = 2;

endpackage

// File: rtl/overcurrent_guard_oc_channel.sv
// One guard channel: comparator synchronizer, glitch filter, trip/retry FSM
// and registered gating of that channel's enable and direction bits.
module oc_channel
    import overcurrent_guard_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES   = FILTER_CYCLES_DEF,
    parameter int unsigned COOLDOWN_CYCLES = COOLDOWN_CYCLES_DEF,
    parameter int unsigned MAX_RETRIES     = MAX_RETRIES_DEF,
    parameter int unsigned CLEAR_CYCLES    = CLEAR_CYCLES_DEF
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                comp_i,
    input  logic                en_i,
    input  logic [CH_DIR_W-1:0] dir_i,
    input  logic                clear_fault_i,
    output logic                en_o,
    output logic [CH_DIR_W-1:0] dir_o,
    output logic                fault_o,
    output logic [RETRY_W-1:0]  retries_o,
    output ch_state_e           state_o
);

    localparam int unsigned FILT_W = $clog2(FILTER_CYCLES + 1);
    localparam int unsigned CD_W   = $clog2(COOLDOWN_CYCLES + 1);
    localparam int unsigned CLR_W  = $clog2(CLEAR_CYCLES + 1);

    logic [1:0]          sync_q;
    logic                comp_s;
    ch_state_e           state_q, state_d;
    logic [FILT_W-1:0]   filt_q, filt_d;
    logic [CD_W-1:0]     cd_q, cd_d;
    logic [CLR_W-1:0]    clean_q, clean_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic                en_q, en_d;
    logic [CH_DIR_W-1:0] dir_q, dir_d;
    logic                fault_q, fault_d;

    assign comp_s = sync_q[1];

    // Two-flop synchronizer for the asynchronous comparator.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], comp_i};
        end
    end

    // FSM and counter state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARMED;
            filt_q  <= '0;
            cd_q    <= '0;
            clean_q <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            filt_q  <= filt_d;
            cd_q    <= cd_d;
            clean_q <= clean_d;
            retry_q <= retry_d;
        end
    end

    // Next-state logic: filter, trip accounting, cooldown timer, lockout release.
    always_comb begin
        state_d = state_q;
        filt_d  = filt_q;
        cd_d    = cd_q;
        clean_d = clean_q;
        retry_d = retry_q;
        unique case (state_q)
            ARMED: begin
                if (filt_q == FILT_W'(FILTER_CYCLES)) begin
                    state_d = TRIP;
                    filt_d  = '0;
                    clean_d = '0;
                end else begin
                    filt_d = comp_s ? filt_q + FILT_W'(1) : '0;
                    // Long quiet stretch forgives earlier trips; saturate so it stays forgiven.
                    if (filt_q == '0) begin
                        if (clean_q == CLR_W'(CLEAR_CYCLES - 1)) begin
                            retry_d = '0;
                        end else begin
                            clean_d = clean_q + CLR_W'(1);
                        end
                    end else begin
                        clean_d = '0;
                    end
                    if (clear_fault_i) begin
                        retry_d = '0;
                    end
                end
            end
            TRIP: begin
                if (retry_q < RETRY_W'(MAX_RETRIES)) begin
                    retry_d = retry_q + RETRY_W'(1);
                end
                state_d = (retry_d < RETRY_W'(MAX_RETRIES)) ? COOLDOWN : LOCKOUT;
                cd_d    = '0;
            end
            COOLDOWN: begin
                if (cd_q == CD_W'(COOLDOWN_CYCLES - 1)) begin
                    state_d = ARMED;
                    cd_d    = '0;
                    filt_d  = '0;
                    clean_d = '0;
                end else begin
                    cd_d = cd_q + CD_W'(1);
                end
            end
            LOCKOUT: begin
                if (clear_fault_i && !comp_s) begin
                    state_d = ARMED;
                    retry_d = '0;
                    filt_d  = '0;
                    clean_d = '0;
                end
            end
            default: begin
                state_d = ARMED;
            end
        endcase
    end

    // Next values of the gated outputs, derived from the current state.
    always_comb begin
        en_d    = en_i && (state_q == ARMED);
        dir_d   = (state_q == ARMED) ? dir_i : '0;
        fault_d = (state_q != ARMED);
    end

    // Output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q    <= 1'b0;
            dir_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            en_q    <= en_d;
            dir_q   <= dir_d;
            fault_q <= fault_d;
        end
    end

    assign en_o      = en_q;
    assign dir_o     = dir_q;
    assign fault_o   = fault_q;
    assign retries_o = retry_q;
    assign state_o   = state_q;

endmodule

// File: rtl/overcurrent_guard.sv
// Dual-channel motor-driver overcurrent guard: two independent oc_channel
// instances plus the shared, registered lockout flag.
module overcurrent_guard
    import overcurrent_guard_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES   = FILTER_CYCLES_DEF,
    parameter int unsigned COOLDOWN_CYCLES = COOLDOWN_CYCLES_DEF,
    parameter int unsigned MAX_RETRIES     = MAX_RETRIES_DEF,
    parameter int unsigned CLEAR_CYCLES    = CLEAR_CYCLES_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               compA,
    input  logic               compB,
    input  logic               enA_in,
    input  logic               enB_in,
    input  logic [3:0]         dir_in,
    input  logic               clear_fault,
    output logic               enableA,
    output logic               enableB,
    output logic [3:0]         dir_out,
    output logic               faultA,
    output logic               faultB,
    output logic               lockout,
    output logic [RETRY_W-1:0] retriesA,
    output logic [RETRY_W-1:0] retriesB
);

    ch_state_e state_a, state_b;
    logic      lockout_q, lockout_d;

    oc_channel #(
        .FILTER_CYCLES  (FILTER_CYCLES),
        .COOLDOWN_CYCLES(COOLDOWN_CYCLES),
        .MAX_RETRIES    (MAX_RETRIES),
        .CLEAR_CYCLES   (CLEAR_CYCLES)
    ) u_ch_a (
        .clk_i        (clock),
        .rst_ni       (reset),
        .comp_i       (compA),
        .en_i         (enA_in),
        .dir_i        (dir_in[1:0]),
        .clear_fault_i(clear_fault),
        .en_o         (enableA),
        .dir_o        (dir_out[1:0]),
        .fault_o      (faultA),
        .retries_o    (retriesA),
        .state_o      (state_a)
    );

    oc_channel #(
        .FILTER_CYCLES  (FILTER_CYCLES),
        .COOLDOWN_CYCLES(COOLDOWN_CYCLES),
        .MAX_RETRIES    (MAX_RETRIES),
        .CLEAR_CYCLES   (CLEAR_CYCLES)
    ) u_ch_b (
        .clk_i        (clock),
        .rst_ni       (reset),
        .comp_i       (compB),
        .en_i         (enB_in),
        .dir_i        (dir_in[3:2]),
        .clear_fault_i(clear_fault),
        .en_o         (enableB),
        .dir_o        (dir_out[3:2]),
        .fault_o      (faultB),
        .retries_o    (retriesB),
        .state_o      (state_b)
    );

    // Either channel locked out raises the shared flag.
    always_comb begin
        lockout_d = (state_a == LOCKOUT) || (state_b == LOCKOUT);
    end

    // Lockout flag register, aligned with the per-channel fault outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lockout_q <= 1'b0;
        end else begin
            lockout_q <= lockout_d;
        end
    end

    assign lockout = lockout_q;

endmodule

// File: tb/tb_overcurrent_guard.sv
// Directed bench for overcurrent_guard with default parameters.
// Step k (k>=1) ends 1 ns after the k-th rising edge following the stimulus
// change; the first of those edges is the one that first samples the new comp.
module tb_overcurrent_guard;

    logic       clk;
    logic       rst_n;
    logic       compA, compB, enA, enB, clr;
    logic [3:0] dir_in;
    logic       enableA, enableB, faultA, faultB, lockout;
    logic [3:0] dir_out;
    logic [1:0] retriesA, retriesB;

    int n_cmp;
    int n_err;

    overcurrent_guard dut (
        .clock      (clk),
        .reset      (rst_n),
        .compA      (compA),
        .compB      (compB),
        .enA_in     (enA),
        .enB_in     (enB),
        .dir_in     (dir_in),
        .clear_fault(clr),
        .enableA    (enableA),
        .enableB    (enableB),
        .dir_out    (dir_out),
        .faultA     (faultA),
        .faultB     (faultB),
        .lockout    (lockout),
        .retriesA   (retriesA),
        .retriesB   (retriesB)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        compA  = 1'b0;
        compB  = 1'b0;
        enA    = 1'b1;
        enB    = 1'b1;
        clr    = 1'b0;
        dir_in = 4'b1011;
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
    endtask

    task automatic test_reset();
        logic [13:0] all_out;
        rst_n  = 1'b0;
        enA    = 1'b1;
        enB    = 1'b1;
        dir_in = 4'b1011;
        #2;
        all_out = {enableA, enableB, dir_out, faultA, faultB, lockout, retriesA, retriesB};
        n_cmp++;
        if (all_out !== 14'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want %b", all_out, 14'd0);
        end
        step();
        rst_n = 1'b1;
        step();
        n_cmp++;
        if ({enableA, enableB, dir_out, faultA, faultB} !== 8'b11_1011_00) begin
            n_err++;
            $display("FAIL reset_release: got %b want %b",
                     {enableA, enableB, dir_out, faultA, faultB}, 8'b11_1011_00);
        end
    endtask

    task automatic test_single_trip();
        do_reset();
        compA = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            if (c == 11) compA = 1'b0;
            step();
            n_cmp++;
            if (enableB !== 1'b1) begin
                n_err++;
                $display("FAIL trip_enB_c%0d: got %b want 1", c, enableB);
            end
            if (c == 7) begin
                n_cmp++;
                if (enableA !== 1'b1) begin
                    n_err++;
                    $display("FAIL trip_enA_before: got %b want 1", enableA);
                end
            end
            if (c == 8) begin
                n_cmp++;
                if ({enableA, faultA, retriesA, dir_out[1:0]} !== 6'b0_1_01_00) begin
                    n_err++;
                    $display("FAIL trip_at_7: got %b want %b",
                             {enableA, faultA, retriesA, dir_out[1:0]}, 6'b0_1_01_00);
                end
            end
        end
    endtask

    task automatic test_glitch();
        do_reset();
        for (int c = 1; c <= 27; c++) begin
            compA = (c <= 3) || (c >= 5 && c <= 7);
            step();
            n_cmp++;
            if ({enableA, faultA, retriesA, dir_out[1:0]} !== 6'b1_0_00_11) begin
                n_err++;
                $display("FAIL glitch_c%0d: got %b want %b", c,
                         {enableA, faultA, retriesA, dir_out[1:0]}, 6'b1_0_00_11);
            end
        end
        compA = 1'b0;
    endtask

    task automatic test_filter_boundary();
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            compA = (c <= 4);
            step();
            if (c == 7) begin
                n_cmp++;
                if (faultA !== 1'b0) begin
                    n_err++;
                    $display("FAIL boundary_pre: got %b want 0", faultA);
                end
            end
            if (c == 8) begin
                n_cmp++;
                if ({faultA, retriesA} !== 3'b1_01) begin
                    n_err++;
                    $display("FAIL boundary_trip: got %b want %b", {faultA, retriesA}, 3'b1_01);
                end
            end
        end
    endtask

    task automatic test_lockout();
        do_reset();
        compA = 1'b1;
        for (int c = 1; c <= 53; c++) begin
            step();
            if (c == 24) begin
                n_cmp++;
                if (enableA !== 1'b0) begin
                    n_err++;
                    $display("FAIL cooldown_end: got %b want 0", enableA);
                end
            end
            if (c == 25) begin
                n_cmp++;
                if ({enableA, faultA, retriesA} !== 4'b1_0_01) begin
                    n_err++;
                    $display("FAIL rearm1: got %b want %b", {enableA, faultA, retriesA}, 4'b1_0_01);
                end
            end
            if (c == 30) begin
                n_cmp++;
                if ({enableA, retriesA} !== 3'b0_10) begin
                    n_err++;
                    $display("FAIL trip2: got %b want %b", {enableA, retriesA}, 3'b0_10);
                end
            end
            if (c == 52) begin
                n_cmp++;
                if ({retriesA, lockout} !== 3'b11_0) begin
                    n_err++;
                    $display("FAIL trip3: got %b want %b", {retriesA, lockout}, 3'b11_0);
                end
            end
            if (c == 53) begin
                n_cmp++;
                if ({lockout, faultA, retriesA, dir_out, enableA, faultB} !== 10'b1_1_11_1000_0_0) begin
                    n_err++;
                    $display("FAIL lockout_entry: got %b want %b",
                             {lockout, faultA, retriesA, dir_out, enableA, faultB}, 10'b1_1_11_1000_0_0);
                end
            end
        end
        // Acknowledge while overcurrent persists must be refused.
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (3) step();
        n_cmp++;
        if ({lockout, retriesA} !== 3'b1_11) begin
            n_err++;
            $display("FAIL lockout_hold: got %b want %b", {lockout, retriesA}, 3'b1_11);
        end
        compA = 1'b0;
        repeat (3) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        n_cmp++;
        if (retriesA !== 2'b00) begin
            n_err++;
            $display("FAIL lockout_clear_retries: got %b want 00", retriesA);
        end
        step();
        n_cmp++;
        if ({lockout, faultA, enableA, dir_out[1:0]} !== 5'b0_0_1_11) begin
            n_err++;
            $display("FAIL lockout_release: got %b want %b",
                     {lockout, faultA, enableA, dir_out[1:0]}, 5'b0_0_1_11);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        compA = 1'b1;
        compB = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            if (c == 11) begin
                compA = 1'b0;
                compB = 1'b0;
            end
            step();
            if (c == 7) begin
                n_cmp++;
                if ({faultA, faultB} !== 2'b00) begin
                    n_err++;
                    $display("FAIL simul_pre: got %b want 00", {faultA, faultB});
                end
            end
            if (c == 8) begin
                n_cmp++;
                if ({faultA, faultB, retriesA, retriesB, enableA, enableB} !== 8'b11_01_01_00) begin
                    n_err++;
                    $display("FAIL simul_trip: got %b want %b",
                             {faultA, faultB, retriesA, retriesB, enableA, enableB}, 8'b11_01_01_00);
                end
            end
        end
    endtask

    task automatic test_clear_fault();
        do_reset();
        compA = 1'b1;
        for (int c = 1; c <= 90; c++) begin
            if (c == 11) compA = 1'b0;
            clr = (c == 15);
            step();
            if (c == 20) begin
                n_cmp++;
                if (retriesA !== 2'b01) begin
                    n_err++;
                    $display("FAIL clear_in_cooldown: got %b want 01", retriesA);
                end
            end
            if (c == 87) begin
                n_cmp++;
                if (retriesA !== 2'b01) begin
                    n_err++;
                    $display("FAIL quiet_before: got %b want 01", retriesA);
                end
            end
            if (c == 88) begin
                n_cmp++;
                if (retriesA !== 2'b00) begin
                    n_err++;
                    $display("FAIL quiet_clear: got %b want 00", retriesA);
                end
            end
        end
        clr = 1'b0;
        compA = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            if (c == 11) compA = 1'b0;
            clr = (c == 28);
            step();
            if (c == 27) begin
                n_cmp++;
                if (retriesA !== 2'b01) begin
                    n_err++;
                    $display("FAIL armed_clear_pre: got %b want 01", retriesA);
                end
            end
            if (c == 28) begin
                n_cmp++;
                if (retriesA !== 2'b00) begin
                    n_err++;
                    $display("FAIL armed_clear: got %b want 00", retriesA);
                end
            end
        end
        clr = 1'b0;
    endtask

    task automatic test_reset_cooldown();
        logic [13:0] all_out;
        do_reset();
        compA = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            if (c == 11) compA = 1'b0;
            step();
        end
        n_cmp++;
        if ({faultA, enableA} !== 2'b10) begin
            n_err++;
            $display("FAIL rc_in_cooldown: got %b want 10", {faultA, enableA});
        end
        #2;
        rst_n = 1'b0;
        #1;
        all_out = {enableA, enableB, dir_out, faultA, faultB, lockout, retriesA, retriesB};
        n_cmp++;
        if (all_out !== 14'd0) begin
            n_err++;
            $display("FAIL rc_async_reset: got %b want %b", all_out, 14'd0);
        end
        #2;
        rst_n = 1'b1;
        step();
        n_cmp++;
        if ({enableA, faultA, retriesA, lockout} !== 5'b1_0_00_0) begin
            n_err++;
            $display("FAIL rc_release: got %b want %b", {enableA, faultA, retriesA, lockout}, 5'b1_0_00_0);
        end
        enA = 1'b0;
        step();
        n_cmp++;
        if (enableA !== 1'b0) begin
            n_err++;
            $display("FAIL rc_follow: got %b want 0", enableA);
        end
        enA = 1'b1;
    endtask

    initial begin
        clk    = 1'b0;
        rst_n  = 1'b0;
        compA  = 1'b0;
        compB  = 1'b0;
        enA    = 1'b0;
        enB    = 1'b0;
        clr    = 1'b0;
        dir_in = 4'b0000;
        n_cmp  = 0;
        n_err  = 0;
        test_reset();
        test_single_trip();
        test_glitch();
        test_filter_boundary();
        test_lockout();
        test_simultaneous();
        test_clear_fault();
        test_reset_cooldown();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
